// File: rtl/counter_sweep_ctrl.sv
// Sequencer for an external up/down counter: sweeps it 0 -> limit -> 0 a programmed
// number of times, mirrors the expected count and flags any divergence.
module counter_sweep_ctrl #(
  parameter int WIDTH    = 4,
  parameter int SWEEPS_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    limit,
  input  logic [SWEEPS_W-1:0] sweeps,
  input  logic [WIDTH-1:0]    count,
  output logic                cnt_rst_n,
  output logic                cnt_up,
  output logic                busy,
  output logic                done,
  output logic [SWEEPS_W-1:0] sweep_idx,
  output logic                error,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                cnt_rst_n_q, cnt_rst_n_d;
  logic                cnt_up_q, cnt_up_d;
  logic [SWEEPS_W-1:0] sweep_idx_q, sweep_idx_d;
  logic                error_q, error_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [WIDTH-1:0]    limit_q, limit_d;
  logic [SWEEPS_W-1:0] sweeps_q, sweeps_d;
  logic [WIDTH-1:0]    exp_inc;
  logic [SWEEPS_W-1:0] sweep_inc;

  assign exp_inc   = exp_q + WIDTH'(1);
  assign sweep_inc = sweep_idx_q + SWEEPS_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_rst_n_d = cnt_rst_n_q;
    cnt_up_d    = cnt_up_q;
    sweep_idx_d = sweep_idx_q;
    error_d     = error_q;
    limit_d     = limit_q;
    sweeps_d    = sweeps_q;

    // Shadow of the counter: follows exactly what the counter is being told to do.
    if (!cnt_rst_n_q)  exp_d = '0;
    else if (cnt_up_q) exp_d = exp_inc;
    else               exp_d = exp_q - WIDTH'(1);

    if ((state_q == S_UP || state_q == S_DOWN) && count != exp_q) error_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        cnt_rst_n_d = 1'b0;
        cnt_up_d    = 1'b1;
        if (start && !abort) begin
          limit_d  = limit;
          sweeps_d = sweeps;
          error_d  = 1'b0;
          state_d  = (limit == '0 || sweeps == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR, S_UP, S_DOWN: begin
        if (abort) begin
          state_d     = S_IDLE;
          cnt_rst_n_d = 1'b0;
          cnt_up_d    = 1'b1;
        end else if (state_q == S_CLEAR) begin
          state_d     = S_UP;
          cnt_rst_n_d = 1'b1;
          cnt_up_d    = 1'b1;
          sweep_idx_d = '0;
        end else if (state_q == S_UP) begin
          if (exp_inc == limit_q) begin
            state_d  = S_DOWN;
            cnt_up_d = 1'b0;
          end
        end else if (exp_q == WIDTH'(1)) begin
          if (sweep_inc < sweeps_q) begin
            state_d     = S_UP;
            cnt_up_d    = 1'b1;
            sweep_idx_d = sweep_inc;
          end else begin
            state_d     = S_DONE;
            cnt_rst_n_d = 1'b0;
            cnt_up_d    = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cnt_rst_n_d = 1'b0;
        cnt_up_d    = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cnt_rst_n_d = 1'b0;
        cnt_up_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_rst_n_q <= 1'b0;
      cnt_up_q    <= 1'b1;
      sweep_idx_q <= '0;
      error_q     <= 1'b0;
      exp_q       <= '0;
      limit_q     <= '0;
      sweeps_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      cnt_up_q    <= cnt_up_d;
      sweep_idx_q <= sweep_idx_d;
      error_q     <= error_d;
      exp_q       <= exp_d;
      limit_q     <= limit_d;
      sweeps_q    <= sweeps_d;
    end
  end

  assign cnt_rst_n = cnt_rst_n_q;
  assign cnt_up    = cnt_up_q;
  assign busy      = (state_q == S_CLEAR) || (state_q == S_UP) || (state_q == S_DOWN);
  assign done      = (state_q == S_DONE);
  assign sweep_idx = sweep_idx_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule
